simple_axi_cmd_queue: RTL and testbench

- Command/response queueing front-end placed directly upstream of simple_axi_master.
- Accepts single-beat read/write commands over a valid/ready stream, buffers them in a command FIFO, and drives the master's i_size/i_addr/i_wdata/i_rw/i_clear port one command at a time.
- Captures each completion (rdata, error, invalid) from the master into a response FIFO with the command's tag.
- Shares i_clk/i_rst with the master.

---
 rtl/simple_axi_cmd_queue_if.sv | 29 ++
 rtl/simple_axi_cmd_queue.sv | 112 +++++++++++
 tb/tb_simple_axi_cmd_queue.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/simple_axi_cmd_queue_if.sv
// simple_axi_cmd_queue_if: command/response streams plus the link to simple_axi_master
interface simple_axi_cmd_queue_if #(parameter int TAG_W = 4);
   logic             i_cmd_valid, o_cmd_ready, i_cmd_write;
   logic [2:0]       i_cmd_size;
   logic [31:0]      i_cmd_addr;
   logic [63:0]      i_cmd_wdata;
   logic [TAG_W-1:0] i_cmd_tag;
   logic             o_rsp_valid, i_rsp_ready, o_rsp_write, o_rsp_error, o_rsp_invalid;
   logic [TAG_W-1:0] o_rsp_tag;
   logic [63:0]      o_rsp_rdata;
   logic             o_busy;
   logic [2:0]       m_size;
   logic [31:0]      m_addr;
   logic [63:0]      m_wdata, m_rdata;
   logic [1:0]       m_rw;
   logic             m_clear, m_wait, m_done, m_error, m_invalid;
   modport slave (
      input  i_cmd_valid, i_cmd_write, i_cmd_size, i_cmd_addr, i_cmd_wdata, i_cmd_tag, i_rsp_ready,
      input  m_rdata, m_wait, m_done, m_error, m_invalid,
      output o_cmd_ready, o_rsp_valid, o_rsp_tag, o_rsp_write, o_rsp_rdata, o_rsp_error, o_rsp_invalid,
      output o_busy, m_size, m_addr, m_wdata, m_rw, m_clear
   );
   modport master (
      output i_cmd_valid, i_cmd_write, i_cmd_size, i_cmd_addr, i_cmd_wdata, i_cmd_tag, i_rsp_ready,
      output m_rdata, m_wait, m_done, m_error, m_invalid,
      input  o_cmd_ready, o_rsp_valid, o_rsp_tag, o_rsp_write, o_rsp_rdata, o_rsp_error, o_rsp_invalid,
      input  o_busy, m_size, m_addr, m_wdata, m_rw, m_clear
   );
endinterface

// File: rtl/simple_axi_cmd_queue.sv
// simple_axi_cmd_queue: command FIFO feeding simple_axi_master one command at a time, response FIFO for completions
module simple_axi_cmd_queue #(
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4,
   parameter int TAG_W     = 4
) (
   input logic i_clk,
   input logic i_rst,
   simple_axi_cmd_queue_if.slave bus
);
   localparam int CAW = $clog2(CMD_DEPTH);
   localparam int RAW = $clog2(RSP_DEPTH);
   localparam logic [CAW:0] CMD_N = (CAW+1)'(CMD_DEPTH);
   localparam logic [RAW:0] RSP_N = (RAW+1)'(RSP_DEPTH);
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             write;
      logic [2:0]       size;
      logic [31:0]      addr;
      logic [63:0]      wdata;
   } cmd_t;
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             write;
      logic [63:0]      rdata;
      logic             error;
      logic             invalid;
   } rsp_t;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   cmd_t             cmd_mem [CMD_DEPTH];
   rsp_t             rsp_mem [RSP_DEPTH];
   logic [CAW-1:0]   cmd_wp, cmd_rp;
   logic [RAW-1:0]   rsp_wp, rsp_rp;
   logic [CAW:0]     cmd_cnt;
   logic [RAW:0]     rsp_cnt;
   state_t           state, state_nx;
   logic [TAG_W-1:0] fl_tag;
   logic             fl_write;
   logic             cmd_ne, cmd_push, cmd_pop, rsp_push, rsp_pop, bad_size;
   cmd_t             head;
   rsp_t             rsp_head, rsp_in;

   assign cmd_ne   = cmd_cnt != '0;
   assign head     = cmd_ne ? cmd_mem[cmd_rp] : '0;
   assign bad_size = head.size > 3'd3;
   assign cmd_push = bus.i_cmd_valid && bus.o_cmd_ready;
   assign cmd_pop  = state == S_ISSUE;
   assign rsp_pop  = bus.o_rsp_valid && bus.i_rsp_ready;
   assign rsp_head = bus.o_rsp_valid ? rsp_mem[rsp_rp] : '0;

   assign bus.o_cmd_ready   = cmd_cnt != CMD_N;
   assign bus.o_rsp_valid   = rsp_cnt != '0;
   assign bus.o_rsp_tag     = rsp_head.tag;
   assign bus.o_rsp_write   = rsp_head.write;
   assign bus.o_rsp_rdata   = rsp_head.rdata;
   assign bus.o_rsp_error   = rsp_head.error;
   assign bus.o_rsp_invalid = rsp_head.invalid;
   assign bus.o_busy        = cmd_ne || state != S_IDLE;
   assign bus.m_size        = head.size;
   assign bus.m_addr        = head.addr;
   assign bus.m_wdata       = head.wdata;
   assign bus.m_clear       = 1'b1;

   always_ff @(posedge i_clk)
      if (cmd_push) cmd_mem[cmd_wp] <= '{tag: bus.i_cmd_tag, write: bus.i_cmd_write, size: bus.i_cmd_size,
                                         addr: bus.i_cmd_addr, wdata: bus.i_cmd_wdata};

   always_ff @(posedge i_clk)
      if (rsp_push) rsp_mem[rsp_wp] <= rsp_in;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cmd_wp  <= '0;
         cmd_rp  <= '0;
         cmd_cnt <= '0;
         rsp_wp  <= '0;
         rsp_rp  <= '0;
         rsp_cnt <= '0;
      end else begin
         cmd_wp  <= cmd_wp + CAW'(cmd_push);
         cmd_rp  <= cmd_rp + CAW'(cmd_pop);
         cmd_cnt <= cmd_cnt + (CAW+1)'(cmd_push) - (CAW+1)'(cmd_pop);
         rsp_wp  <= rsp_wp + RAW'(rsp_push);
         rsp_rp  <= rsp_rp + RAW'(rsp_pop);
         rsp_cnt <= rsp_cnt + (RAW+1)'(rsp_push) - (RAW+1)'(rsp_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      state <= i_rst ? S_IDLE : state_nx;
      if (state == S_ISSUE) begin
         fl_tag   <= head.tag;
         fl_write <= head.write;
      end
   end

   // Issue only with a free response slot: the single outstanding command can then always retire
   always_comb
      state_nx = state == S_IDLE  ? ((cmd_ne && rsp_cnt != RSP_N) ? S_ISSUE : S_IDLE) :
                 state == S_ISSUE ? ((bad_size || bus.m_done) ? S_IDLE : S_WAIT) :
                 (bus.m_done ? S_IDLE : S_WAIT);

   always_comb begin
      bus.m_rw       = (state == S_ISSUE && !bad_size) ? (head.write ? 2'b01 : 2'b10) : 2'b00;
      rsp_push       = (state == S_ISSUE && (bad_size || bus.m_done)) || (state == S_WAIT && bus.m_done);
      rsp_in.tag     = state == S_WAIT ? fl_tag : head.tag;
      rsp_in.write   = state == S_WAIT ? fl_write : head.write;
      rsp_in.rdata   = (state == S_WAIT && !fl_write && !bus.m_error) ? bus.m_rdata : 64'd0;
      rsp_in.error   = (state == S_ISSUE && bad_size) || bus.m_error;
      rsp_in.invalid = (state == S_ISSUE && bad_size) || bus.m_invalid;
   end
endmodule

// File: tb/tb_simple_axi_cmd_queue.sv
// tb_simple_axi_cmd_queue: directed vectors against a small behavioural model of simple_axi_master
module tb_simple_axi_cmd_queue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0, n_pass = 0, rw_cnt = 0, mode = 0;
   simple_axi_cmd_queue_if #(.TAG_W(4)) bus();
   simple_axi_cmd_queue #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TAG_W(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Master model: rejects misaligned commands in the issue cycle, otherwise completes after a short wait.
   // mode 0 = OKAY, 1 = SLVERR, 2 = DECERR. Garbage rdata whenever the queue must zero it.
   logic        mb, mw, misal, fin;
   logic [1:0]  lat;
   logic [63:0] mwd, mem;
   logic [31:0] mask;
   always_comb begin
      mask          = bus.m_size <= 3'd3 ? (32'd1 << bus.m_size) - 32'd1 : 32'd0;
      misal         = bus.m_rw != 2'b00 && !mb && (bus.m_addr & mask) != 32'd0;
      fin           = mb && lat == 2'd0;
      bus.m_done    = misal || fin;
      bus.m_wait    = (bus.m_rw != 2'b00 && !misal) || (mb && !fin);
      bus.m_error   = misal || (fin && mode != 0);
      bus.m_invalid = misal || (fin && mode == 2);
      bus.m_rdata   = (fin && !mw && mode == 0) ? mem : 64'hBAD0_BAD0_BAD0_BAD0;
   end
   always_ff @(posedge clk) begin
      if (bus.m_rw != 2'b00) rw_cnt <= rw_cnt + 1;
      if (rst) mb <= 1'b0;
      else if (mb) begin
         if (lat == 2'd0) begin
            mb <= 1'b0;
            if (mw && mode == 0) mem <= mwd;
         end else lat <= lat - 2'd1;
      end else if (bus.m_rw != 2'b00 && !misal) begin
         mb  <= 1'b1;
         lat <= 2'd2;
         mw  <= bus.m_rw == 2'b01;
         mwd <= bus.m_wdata;
      end
   end

   typedef struct {
      logic        w;
      logic [2:0]  sz;
      logic [31:0] a;
      logic [63:0] wd;
      logic [3:0]  tag;
      int          mode;
      logic [63:0] erd;
      logic        ee, ei;
      int          pulses;
   } vec_t;
   vec_t v [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [63:0] wd,
                       input logic [3:0] tg);
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_write = w;
      bus.i_cmd_size  = sz;
      bus.i_cmd_addr  = a;
      bus.i_cmd_wdata = wd;
      bus.i_cmd_tag   = tg;
      for (int i = 0; i < 100 && !bus.o_cmd_ready; i++) @(negedge clk);
      if (!bus.o_cmd_ready) chk("push_timeout", 64'(bus.o_cmd_ready), 64'd1);
      @(negedge clk);
      bus.i_cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string name);
      for (int i = 0; i < 60 && !bus.o_rsp_valid; i++) @(negedge clk);
      if (!bus.o_rsp_valid) chk({name, "_timeout"}, 64'(bus.o_rsp_valid), 64'd1);
   endtask

   initial begin
      int c0;
      v[0] = '{1'b1, 3'd3, 32'h100, 64'h1122334455667788, 4'd1, 0, 64'd0, 1'b0, 1'b0, 1};
      v[1] = '{1'b0, 3'd3, 32'h100, 64'd0, 4'd2, 0, 64'h1122334455667788, 1'b0, 1'b0, 1};
      v[2] = '{1'b0, 3'd2, 32'h102, 64'd0, 4'd5, 0, 64'd0, 1'b1, 1'b1, 1};
      v[3] = '{1'b0, 3'd5, 32'h100, 64'd0, 4'd6, 0, 64'd0, 1'b1, 1'b1, 0};
      v[4] = '{1'b1, 3'd2, 32'h100, 64'hCAFE, 4'd3, 1, 64'd0, 1'b1, 1'b0, 1};
      v[5] = '{1'b0, 3'd1, 32'h104, 64'd0, 4'd4, 2, 64'd0, 1'b1, 1'b1, 1};
      v[6] = '{1'b0, 3'd3, 32'h100, 64'd0, 4'd7, 0, 64'h1122334455667788, 1'b0, 1'b0, 1};
      bus.i_cmd_valid = 1'b0;
      bus.i_cmd_write = 1'b0;
      bus.i_cmd_size  = 3'd0;
      bus.i_cmd_addr  = 32'd0;
      bus.i_cmd_wdata = 64'd0;
      bus.i_cmd_tag   = 4'd0;
      bus.i_rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 64'(bus.o_cmd_ready), 64'd1);
      chk("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
      chk("rst_busy", 64'(bus.o_busy), 64'd0);
      chk("rst_m_rw", 64'(bus.m_rw), 64'd0);
      chk("rst_m_clear", 64'(bus.m_clear), 64'd1);
      chk("rst_m_addr", 64'(bus.m_addr), 64'd0);
      chk("rst_rsp_tag", 64'(bus.o_rsp_tag), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         mode = v[i].mode;
         c0 = rw_cnt;
         push(v[i].w, v[i].sz, v[i].a, v[i].wd, v[i].tag);
         chk($sformatf("v%0d_rw_t1", i), 64'(bus.m_rw), 64'd0);
         @(negedge clk);
         chk($sformatf("v%0d_rw_t2", i), 64'(bus.m_rw), v[i].pulses == 0 ? 64'd0 : v[i].w ? 64'd1 : 64'd2);
         wait_rsp($sformatf("v%0d", i));
         chk($sformatf("v%0d_tag", i), 64'(bus.o_rsp_tag), 64'(v[i].tag));
         chk($sformatf("v%0d_write", i), 64'(bus.o_rsp_write), 64'(v[i].w));
         chk($sformatf("v%0d_rdata", i), bus.o_rsp_rdata, v[i].erd);
         chk($sformatf("v%0d_error", i), 64'(bus.o_rsp_error), 64'(v[i].ee));
         chk($sformatf("v%0d_invalid", i), 64'(bus.o_rsp_invalid), 64'(v[i].ei));
         chk($sformatf("v%0d_pulses", i), 64'(rw_cnt - c0), 64'(v[i].pulses));
         @(negedge clk);
      end

      // Backpressure: four responses fill the response FIFO, the rest wait in the command FIFO
      mode = 0;
      bus.i_rsp_ready = 1'b0;
      c0 = rw_cnt;
      for (int t = 8; t < 14; t++) push(1'b0, 3'd3, 32'h100, 64'd0, 4'(t));
      repeat (40) @(negedge clk);
      chk("bp_issued", 64'(rw_cnt - c0), 64'd4);
      chk("bp_rsp_valid", 64'(bus.o_rsp_valid), 64'd1);
      chk("bp_m_rw_idle", 64'(bus.m_rw), 64'd0);
      chk("bp_busy", 64'(bus.o_busy), 64'd1);
      push(1'b0, 3'd3, 32'h100, 64'd0, 4'd14);
      push(1'b0, 3'd3, 32'h100, 64'd0, 4'd15);
      chk("bp_cmd_full", 64'(bus.o_cmd_ready), 64'd0);
      bus.i_rsp_ready = 1'b1;
      for (int t = 8; t < 16; t++) begin
         wait_rsp($sformatf("bp%0d", t));
         chk($sformatf("bp%0d_tag", t), 64'(bus.o_rsp_tag), 64'(t));
         chk($sformatf("bp%0d_rdata", t), bus.o_rsp_rdata, 64'h1122334455667788);
         @(negedge clk);
      end
      chk("bp_issued_all", 64'(rw_cnt - c0), 64'd8);
      chk("bp_drained_busy", 64'(bus.o_busy), 64'd0);

      // Reset while a read waits for completion
      push(1'b0, 3'd3, 32'h100, 64'd0, 4'd9);
      for (int i = 0; i < 20 && bus.m_rw == 2'b00; i++) @(negedge clk);
      chk("mr_issued", 64'(bus.m_rw), 64'd2);
      @(negedge clk);
      chk("mr_in_flight", 64'(bus.o_busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_busy", 64'(bus.o_busy), 64'd0);
      chk("mr_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
      chk("mr_cmd_ready", 64'(bus.o_cmd_ready), 64'd1);
      chk("mr_m_rw", 64'(bus.m_rw), 64'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("mr_no_rsp", 64'(bus.o_rsp_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
